// File: rtl/board_renderer_if.sv
// board_renderer_if: pixel stream, board control and colour output of the renderer
interface board_renderer_if #(
    parameter int GRID_N     = 3,
    parameter int COLOR_BITS = 2
);
    localparam int IW = $clog2(GRID_N * GRID_N);
    logic                     video_active;
    logic [9:0]               pix_x;
    logic [9:0]               pix_y;
    logic                     frame_tick;
    logic                     cell_we;
    logic [IW-1:0]            cell_idx;
    logic [1:0]               cell_val;
    logic                     clear;
    logic [IW-1:0]            cursor_idx;
    logic [GRID_N*GRID_N-1:0] win_mask;
    logic [COLOR_BITS-1:0]    R;
    logic [COLOR_BITS-1:0]    G;
    logic [COLOR_BITS-1:0]    B;
    modport master (
        output video_active, pix_x, pix_y, frame_tick, cell_we, cell_idx, cell_val,
               clear, cursor_idx, win_mask,
        input  R, G, B
    );
    modport slave (
        input  video_active, pix_x, pix_y, frame_tick, cell_we, cell_idx, cell_val,
               clear, cursor_idx, win_mask,
        output R, G, B
    );
endinterface

// File: rtl/board_renderer.sv
// board_renderer: two-stage tic-tac-toe board pixel renderer with blinking cursor
module board_renderer #(
    parameter int GRID_N       = 3,
    parameter int CELL_PX      = 128,
    parameter int ORIGIN_X     = 128,
    parameter int ORIGIN_Y     = 48,
    parameter int LINE_PX      = 4,
    parameter int COLOR_BITS   = 2,
    parameter int BLINK_FRAMES = 30
) (
    input logic             clk,
    input logic             reset,
    board_renderer_if.slave bus
);
    localparam int NC   = GRID_N * GRID_N;
    localparam int IW   = $clog2(NC);
    localparam int IW1  = IW + 1;
    localparam int SH   = $clog2(CELL_PX);
    localparam int CW   = (GRID_N > 1) ? $clog2(GRID_N) : 1;
    localparam int OW   = SH + 1;
    localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SPAN = GRID_N * CELL_PX;
    localparam logic [OW-1:0] K_L   = OW'(LINE_PX);
    localparam logic [OW-1:0] K_E   = OW'(CELL_PX - LINE_PX);
    localparam logic [OW-1:0] K_IN  = OW'(CELL_PX / 8);
    localparam logic [OW-1:0] K_OUT = OW'(CELL_PX - CELL_PX / 8);
    localparam logic [OW-1:0] K_RI  = OW'(CELL_PX / 8 + LINE_PX);
    localparam logic [OW-1:0] K_RO  = OW'(CELL_PX - CELL_PX / 8 - LINE_PX);
    localparam logic [OW-1:0] K_D   = OW'(CELL_PX - 1);
    localparam logic [COLOR_BITS-1:0] FULL = '1;
    localparam logic [COLOR_BITS-1:0] DIM  = COLOR_BITS'(1);
    localparam logic [COLOR_BITS-1:0] ZERO = '0;

    logic [1:0]    board [NC];
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic [10:0]   rx, ry;
    logic          act1, in1;
    logic [CW-1:0] col1, row1;
    logic [SH-1:0] offx1, offy1;
    logic [1:0]    cv;
    logic          cur, win;
    logic [OW-1:0] ox, oy, sum, d1, d2;
    logic          band, ring_in, cursor_hit, grid_hit, x_hit, o_hit;
    logic [3*COLOR_BITS-1:0] rgb;

    assign rx = {1'b0, bus.pix_x} - 11'(ORIGIN_X);
    assign ry = {1'b0, bus.pix_y} - 11'(ORIGIN_Y);

    // board storage: clear wins over a write, out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (reset || bus.clear)
            board <= '{default: '0};
        else if (bus.cell_we && {1'b0, bus.cell_idx} < IW1'(NC))
            board[bus.cell_idx] <= bus.cell_val;
    end

    // cursor blink: phase flips every BLINK_FRAMES frame ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (bus.frame_tick) begin
            blink_cnt <= (blink_cnt == BW'(BLINK_FRAMES - 1)) ? '0 : blink_cnt + BW'(1);
            phase     <= phase ^ (blink_cnt == BW'(BLINK_FRAMES - 1));
        end
    end

    // stage 1: board-relative coordinates split into cell and in-cell offset
    always_ff @(posedge clk) begin
        if (reset) begin
            act1 <= 1'b0;
            in1  <= 1'b0;
        end else begin
            act1 <= bus.video_active;
            in1  <= !rx[10] && rx < 11'(SPAN) && !ry[10] && ry < 11'(SPAN);
        end
        col1  <= rx[SH+CW-1:SH];
        row1  <= ry[SH+CW-1:SH];
        offx1 <= rx[SH-1:0];
        offy1 <= ry[SH-1:0];
    end

    // cell lookup by row/col with elaboration-time index mapping
    always_comb begin
        cv  = 2'b00;
        cur = 1'b0;
        win = 1'b0;
        for (int i = 0; i < NC; i++)
            if (row1 == CW'(i / GRID_N) && col1 == CW'(i % GRID_N)) begin
                cv  = board[i];
                cur = bus.cursor_idx == IW'(i);
                win = bus.win_mask[i];
            end
    end

    assign ox         = {1'b0, offx1};
    assign oy         = {1'b0, offy1};
    assign sum        = ox + oy;
    assign d1         = (ox >= oy) ? ox - oy : oy - ox;
    assign d2         = (sum >= K_D) ? sum - K_D : K_D - sum;
    assign band       = ox >= K_IN && ox < K_OUT && oy >= K_IN && oy < K_OUT;
    assign ring_in    = ox >= K_RI && ox < K_RO && oy >= K_RI && oy < K_RO;
    assign cursor_hit = cur && phase && (ox < K_L || ox >= K_E || oy < K_L || oy >= K_E);
    assign grid_hit   = (col1 != '0 && ox < K_L) || (row1 != '0 && oy < K_L);
    assign x_hit      = cv == 2'b01 && band && (d1 < K_L || d2 < K_L);
    assign o_hit      = cv == 2'b10 && band && !ring_in;
    assign rgb = !act1      ? {ZERO, ZERO, ZERO} :
                 !in1       ? {DIM, DIM, DIM}    :
                 cursor_hit ? {FULL, FULL, ZERO} :
                 grid_hit   ? {FULL, FULL, FULL} :
                 x_hit      ? {FULL, ZERO, ZERO} :
                 o_hit      ? {ZERO, ZERO, FULL} :
                 win        ? {ZERO, DIM, ZERO}  : {ZERO, ZERO, ZERO};

    // stage 2: registered colour
    always_ff @(posedge clk) begin
        if (reset)
            {bus.R, bus.G, bus.B} <= '0;
        else
            {bus.R, bus.G, bus.B} <= rgb;
    end
endmodule

// File: tb/tb_board_renderer.sv
// tb_board_renderer: directed and randomized checks against a behavioural board model
module tb_board_renderer;
    localparam int N = 3, C = 128, OX = 128, OY = 48, L = 4, BF = 30, NC = 9;

    logic clk = 0;
    logic reset = 1;
    board_renderer_if #(.GRID_N(N), .COLOR_BITS(2)) bus();
    board_renderer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int mboard [NC];
    int mcnt;
    bit mphase;
    bit p_act;
    int p_x, p_y;
    logic [5:0] exp_rgb;
    bit armed = 0;

    function automatic int iabs(int v);
        return v < 0 ? -v : v;
    endfunction

    // what the screen must show for one pixel given the current board state
    function automatic logic [5:0] ref_rgb(bit act, int x, int y);
        int rx, ry, col, row, ox, oy, idx;
        bit band;
        if (!act) return 6'b000000;
        rx = x - OX;
        ry = y - OY;
        if (rx < 0 || ry < 0 || rx >= N * C || ry >= N * C) return 6'b010101;
        col = rx / C; row = ry / C; ox = rx % C; oy = ry % C;
        idx = row * N + col;
        if (idx == int'(bus.cursor_idx) && mphase && (ox < L || ox >= C - L || oy < L || oy >= C - L))
            return 6'b111100;
        if ((col != 0 && ox < L) || (row != 0 && oy < L)) return 6'b111111;
        band = ox >= C / 8 && ox < C - C / 8 && oy >= C / 8 && oy < C - C / 8;
        if (mboard[idx] == 1 && band && (iabs(ox - oy) < L || iabs(ox + oy - (C - 1)) < L))
            return 6'b110000;
        if (mboard[idx] == 2 && band &&
            (ox < C / 8 + L || ox >= C - C / 8 - L || oy < C / 8 + L || oy >= C - C / 8 - L))
            return 6'b000011;
        if (bus.win_mask[idx]) return 6'b000100;
        return 6'b000000;
    endfunction

    // reference: colour for the pixel captured last edge, then state updates
    always @(posedge clk) begin
        if (reset) begin
            exp_rgb = 6'b0;
            p_act   = 0;
            foreach (mboard[i]) mboard[i] = 0;
            mcnt    = 0;
            mphase  = 1;
            armed   = 1;
        end else begin
            exp_rgb = ref_rgb(p_act, p_x, p_y);
            p_act   = bus.video_active;
            p_x     = int'(bus.pix_x);
            p_y     = int'(bus.pix_y);
            if (bus.clear) foreach (mboard[i]) mboard[i] = 0;
            else if (bus.cell_we && int'(bus.cell_idx) < NC) mboard[bus.cell_idx] = int'(bus.cell_val);
            if (bus.frame_tick) begin
                if (mcnt == BF - 1) begin
                    mcnt   = 0;
                    mphase = !mphase;
                end else mcnt++;
            end
        end
    end

    // continuous compare of DUT colour against the reference
    always @(negedge clk) begin
        if (armed) begin
            tests++;
            if ({bus.R, bus.G, bus.B} !== exp_rgb) begin
                fails++;
                $display("FAIL rgb t=%0t got %b expected %b", $time, {bus.R, bus.G, bus.B}, exp_rgb);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [5:0] want);
        tests++;
        if ({bus.R, bus.G, bus.B} !== want) begin
            fails++;
            $display("FAIL %s got %b expected %b", nm, {bus.R, bus.G, bus.B}, want);
        end
        tests++;
        if (exp_rgb !== want) begin
            fails++;
            $display("FAIL %s_model got %b expected %b", nm, exp_rgb, want);
        end
    endtask

    task automatic show(input int x, input int y, input logic [5:0] want, input string nm);
        bus.pix_x = 10'(x);
        bus.pix_y = 10'(y);
        step;
        step;
        check(nm, want);
    endtask

    task automatic write(input int idx, input int val);
        bus.cell_we  = 1;
        bus.cell_idx = 4'(idx);
        bus.cell_val = 2'(val);
        step;
        bus.cell_we = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.frame_tick = 1;
            step;
            bus.frame_tick = 0;
            step;
        end
    endtask

    initial begin
        bus.video_active = 0; bus.pix_x = 0; bus.pix_y = 0; bus.frame_tick = 0;
        bus.cell_we = 0; bus.cell_idx = 0; bus.cell_val = 0; bus.clear = 0;
        bus.cursor_idx = 8; bus.win_mask = 0;
        repeat (2) step;
        check("reset_black", 6'b000000);
        reset = 0;
        bus.video_active = 1;
        show(0, 0, 6'b010101, "outside_dim");
        reset = 1;
        step;
        check("reset_mid", 6'b000000);
        reset = 0;
        write(4, 1);
        show(320, 240, 6'b110000, "x_center");
        write(4, 2);
        show(320, 240, 6'b000000, "o_center");
        show(272, 240, 6'b000011, "o_ring");
        show(256, 100, 6'b111111, "grid");
        bus.cursor_idx = 1;
        show(130, 100, 6'b000000, "no_grid_col0");
        bus.cursor_idx = 0;
        show(130, 100, 6'b111100, "cursor_on");
        ticks(29);
        check("cursor_29", 6'b111100);
        ticks(1);
        check("cursor_off", 6'b000000);
        ticks(30);
        check("cursor_back", 6'b111100);
        bus.cursor_idx = 8;
        write(0, 1);
        show(192, 112, 6'b110000, "c0_x");
        bus.clear = 1;
        write(0, 1);
        bus.clear = 0;
        show(192, 112, 6'b000000, "clear_prio");
        write(9, 1);
        show(192, 112, 6'b000000, "oob_c0");
        show(320, 112, 6'b000000, "oob_c1");
        bus.win_mask = 9'b000000111;
        show(200, 60, 6'b000100, "win");
        bus.video_active = 0;
        show(200, 60, 6'b000000, "inactive");
        bus.win_mask = 0;
        bus.video_active = 1;
        write(4, 3);
        show(320, 240, 6'b000000, "val11_empty");
        for (int i = 0; i < 4000; i++) begin
            bus.video_active = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 3) != 0) begin
                bus.pix_x = 10'(OX + $urandom_range(0, N * C - 1));
                bus.pix_y = 10'(OY + $urandom_range(0, N * C - 1));
            end else begin
                bus.pix_x = 10'($urandom_range(0, 799));
                bus.pix_y = 10'($urandom_range(0, 524));
            end
            bus.cell_we  = $urandom_range(0, 3) == 0;
            bus.cell_idx = 4'($urandom_range(0, 15));
            bus.cell_val = 2'($urandom_range(0, 3));
            bus.clear    = $urandom_range(0, 63) == 0;
            if ($urandom_range(0, 15) == 0) bus.cursor_idx = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) bus.win_mask = 9'($urandom);
            bus.frame_tick = $urandom_range(0, 3) == 0;
            reset = $urandom_range(0, 299) == 0;
            step;
        end
        reset = 0; bus.cell_we = 0; bus.clear = 0; bus.frame_tick = 0;
        repeat (3) step;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
